// File: rtl/axi_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_mem_slave
// Simple AXI memory slave backed by a DEPTH x DATA_W register array.
// Reads and writes run on two independent FSMs. Each FSM handles one burst
// at a time. All transfers are full width.
//
// Ports
//   clk, areset                : clock, asynchronous active-high reset
//   s_axi_ar*                  : read address channel (addr, id, len, burst)
//   s_axi_r*                   : read data channel (data, id, resp, last)
//   s_axi_aw*                  : write address channel (addr, id, len, burst)
//   s_axi_w*                   : write data channel (data, strb, last)
//   s_axi_b*                   : write response channel (id, resp)
//
// Burst handling
//   FIXED repeats one word. INCR steps one word per beat and wraps modulo DEPTH.
//   WRAP and reserved burst types answer SLVERR and never touch memory.
//   A burst whose start word lies beyond DEPTH also answers SLVERR.
// ---------------------------------------------------------------------------
module axi_mem_slave #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                areset,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [7:0]          s_axi_arlen,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [7:0]          s_axi_awlen,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int AIDX_W = ADDR_W - OFFS;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_W = $clog2(RD_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rState_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;

    // Returns the word index that follows idx for the given burst type.
    // Only INCR moves. Error bursts never use the result.
    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx,
                                                 input logic [1:0]       burst);
        if (burst == BURST_INCR)
            return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
        return idx;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    // ---------------- read side ----------------
    rState_t           r_rState, w_rStateNext;
    logic [IDX_W-1:0]  r_rIdx;
    logic [7:0]        r_rCnt, r_rLen;
    logic [1:0]        r_rBurst, r_rResp;
    logic              r_rErr;
    logic [ID_W-1:0]   r_rId;
    logic [DATA_W-1:0] r_rData;
    logic [WAIT_W-1:0] r_rWait;

    logic [AIDX_W-1:0] w_arWord;
    logic              w_arErr, w_arAccept, w_rFetch, w_rLast;
    logic [IDX_W-1:0]  w_fetchIdx;
    logic              w_fetchErr;
    logic [1:0]        w_fetchBurst;

    assign w_arWord = s_axi_araddr[ADDR_W-1:OFFS];
    assign w_arErr  = (w_arWord >= AIDX_W'(DEPTH)) || s_axi_arburst[1];
    assign w_rLast  = (r_rCnt == r_rLen);

    // The first fetch can happen in the same cycle as the AR handshake.
    // In that case the fetch uses the live AR fields instead of the latched ones.
    assign w_fetchIdx   = (r_rState == R_IDLE) ? w_arWord[IDX_W-1:0] : r_rIdx;
    assign w_fetchErr   = (r_rState == R_IDLE) ? w_arErr : r_rErr;
    assign w_fetchBurst = (r_rState == R_IDLE) ? s_axi_arburst : r_rBurst;

    // Read state register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            r_rState <= R_IDLE;
        else
            r_rState <= w_rStateNext;
    end

    // Read next-state logic.
    // A fetch loads the beat that is presented next.
    // It fires when R_DATA is entered and after every non-final handshake.
    always_comb begin
        w_rStateNext = r_rState;
        w_arAccept   = 1'b0;
        w_rFetch     = 1'b0;
        case (r_rState)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    w_arAccept = 1'b1;
                    if (RD_LAT == 1) begin
                        w_rFetch     = 1'b1;
                        w_rStateNext = R_DATA;
                    end else begin
                        w_rStateNext = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_rWait == '0) begin
                    w_rFetch     = 1'b1;
                    w_rStateNext = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (w_rLast)
                        w_rStateNext = R_IDLE;
                    else
                        w_rFetch = 1'b1;
                end
            end
            default: w_rStateNext = R_IDLE;
        endcase
    end

    // Read datapath.
    // When RD_LAT is 1, the accept and the first fetch share a cycle.
    // The fetch's index update then overrides the accept's.
    // The memory is read before the write array updates on the same edge.
    // So a same-word read and write in one cycle returns the old data.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_rIdx   <= '0;
            r_rCnt   <= '0;
            r_rLen   <= '0;
            r_rBurst <= '0;
            r_rErr   <= 1'b0;
            r_rId    <= '0;
            r_rData  <= '0;
            r_rResp  <= RESP_OKAY;
            r_rWait  <= '0;
        end else begin
            if (w_arAccept) begin
                r_rId    <= s_axi_arid;
                r_rLen   <= s_axi_arlen;
                r_rBurst <= s_axi_arburst;
                r_rErr   <= w_arErr;
                r_rCnt   <= '0;
                r_rWait  <= WAIT_INIT;
                r_rIdx   <= w_arWord[IDX_W-1:0];
            end else if (r_rState == R_WAIT) begin
                r_rWait <= r_rWait - WAIT_W'(1);
            end
            if (w_rFetch) begin
                r_rData <= w_fetchErr ? '0 : r_mem[w_fetchIdx];
                r_rResp <= w_fetchErr ? RESP_SLVERR : RESP_OKAY;
                r_rIdx  <= nextIdx(w_fetchIdx, w_fetchBurst);
            end
            if ((r_rState == R_DATA) && s_axi_rready && !w_rLast)
                r_rCnt <= r_rCnt + 8'd1;
        end
    end

    assign s_axi_arready = (r_rState == R_IDLE);
    assign s_axi_rvalid  = (r_rState == R_DATA);
    assign s_axi_rlast   = (r_rState == R_DATA) && w_rLast;
    assign s_axi_rdata   = r_rData;
    assign s_axi_rid     = r_rId;
    assign s_axi_rresp   = r_rResp;

    // ---------------- write side ----------------
    wState_t           r_wState, w_wStateNext;
    logic [IDX_W-1:0]  r_wIdx;
    logic [7:0]        r_wCnt, r_wLen;
    logic [1:0]        r_wBurst;
    logic              r_wErr;
    logic [ID_W-1:0]   r_wId;

    logic [AIDX_W-1:0] w_awWord;
    logic              w_awErr, w_awAccept, w_wBeat, w_memWe;

    assign w_awWord = s_axi_awaddr[ADDR_W-1:OFFS];
    assign w_awErr  = (w_awWord >= AIDX_W'(DEPTH)) || s_axi_awburst[1];
    assign w_memWe  = w_wBeat && !r_wErr;

    // Write state register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            r_wState <= W_IDLE;
        else
            r_wState <= w_wStateNext;
    end

    // Write next-state logic.
    // The beat count alone decides when the burst ends. WLAST is not used.
    always_comb begin
        w_wStateNext = r_wState;
        w_awAccept   = 1'b0;
        w_wBeat      = 1'b0;
        case (r_wState)
            W_IDLE: begin
                if (s_axi_awvalid) begin
                    w_awAccept   = 1'b1;
                    w_wStateNext = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    w_wBeat = 1'b1;
                    if (r_wCnt == r_wLen)
                        w_wStateNext = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready)
                    w_wStateNext = W_IDLE;
            end
            default: w_wStateNext = W_IDLE;
        endcase
    end

    // Write burst bookkeeping.
    // An erroring burst is known at AW time, so a single flag covers every beat.
    // That flag produces exactly one SLVERR response for the burst.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wIdx   <= '0;
            r_wCnt   <= '0;
            r_wLen   <= '0;
            r_wBurst <= '0;
            r_wErr   <= 1'b0;
            r_wId    <= '0;
        end else begin
            if (w_awAccept) begin
                r_wId    <= s_axi_awid;
                r_wLen   <= s_axi_awlen;
                r_wBurst <= s_axi_awburst;
                r_wErr   <= w_awErr;
                r_wCnt   <= '0;
                r_wIdx   <= w_awWord[IDX_W-1:0];
            end
            if (w_wBeat) begin
                r_wCnt <= r_wCnt + 8'd1;
                r_wIdx <= nextIdx(r_wIdx, r_wBurst);
            end
        end
    end

    // Storage array with per-byte enables.
    // It is deliberately not reset, so its contents after reset are whatever was left.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b])
                    r_mem[r_wIdx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi_awready = (r_wState == W_IDLE);
    assign s_axi_wready  = (r_wState == W_DATA);
    assign s_axi_bvalid  = (r_wState == W_RESP);
    assign s_axi_bid     = r_wId;
    assign s_axi_bresp   = r_wErr ? RESP_SLVERR : RESP_OKAY;

    // Sub-word address bits and WLAST carry no information for this slave.
    logic w_unused;
    assign w_unused = &{1'b0, s_axi_wlast, s_axi_araddr[OFFS-1:0], s_axi_awaddr[OFFS-1:0]};

endmodule
